// File: rtl/cavlc_level_stream_encoder_pkg.sv
// Shared types, constants and level-code helpers for the CAVLC level encoder.
package cavlc_level_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_EVAL,
        ST_CALC,
        ST_PREFIX,
        ST_SUFFIX,
        ST_DONE
    } state_t;

    localparam int MAX_SUFFIX_LEN  = 6;
    localparam int ESC_PREFIX      = 15;
    localparam int ESC_SUFFIX_BITS = 12;
    localparam int SL0_ESC4_BASE   = 14;
    localparam int SL0_ESC12_BASE  = 30;

    // Working width for the helpers; wide enough for any legal DATA_WIDTH.
    localparam int CODE_W = 16;

    // Maps a nonzero signed level to its unsigned level_code.
    // first_adj removes the offset applied to the first coded level when T1s < 3.
    function automatic logic [CODE_W-1:0] level_code_f(
        input logic signed [CODE_W-1:0] level,
        input logic                     first_adj
    );
        logic [CODE_W-1:0] lc;
        if (!level[CODE_W-1])
            lc = (unsigned'(level) << 1) - CODE_W'(2);
        else
            lc = (unsigned'(-level) << 1) - CODE_W'(1);
        if (first_adj)
            lc = lc - CODE_W'(2);
        return lc;
    endfunction

    // Level codes at or above this value use the 12-bit escape when sl > 0.
    function automatic logic [CODE_W-1:0] esc_threshold(input logic [2:0] sl);
        return CODE_W'(ESC_PREFIX) << sl;
    endfunction

    // |level| above this value bumps the suffix length.
    function automatic logic [CODE_W-1:0] sl_bump_threshold(input logic [2:0] sl);
        return CODE_W'(3) << (sl - 3'd1);
    endfunction

endpackage

// File: rtl/cavlc_level_stream_encoder_if.sv
// Coefficient BRAM read port and bitstream FIFO write port of the level encoder.
interface cavlc_level_stream_encoder_if #(
    parameter int DATA_WIDTH = 9,
    parameter int ADDR_WIDTH = 4
);
    logic                         mb_bram_en;
    logic [ADDR_WIDTH-1:0]        mb_bram_address;
    logic signed [DATA_WIDTH-1:0] mb_bram_data;
    logic                         o_fifo_data;
    logic                         o_fifo_push;
    logic                         i_fifo_full;

    modport master (
        output mb_bram_en,
        output mb_bram_address,
        input  mb_bram_data,
        output o_fifo_data,
        output o_fifo_push,
        input  i_fifo_full
    );

    modport slave (
        input  mb_bram_en,
        input  mb_bram_address,
        output mb_bram_data,
        input  o_fifo_data,
        input  o_fifo_push,
        output i_fifo_full
    );
endinterface

// File: rtl/cavlc_level_stream_encoder_code_calc.sv
// Combinational level_code -> prefix/suffix mapping and suffixLength update.
module cavlc_level_code_calc
    import cavlc_level_pkg::*;
#(
    parameter int DATA_WIDTH = 9
) (
    input  logic signed [DATA_WIDTH-1:0] level,
    input  logic [2:0]                   sl,
    input  logic                         first_flag,
    input  logic [1:0]                   t1s,
    output logic [3:0]                   prefix,
    output logic [11:0]                  suffix,
    output logic [3:0]                   suffix_len,
    output logic [2:0]                   next_sl
);
    localparam int LC_W = DATA_WIDTH + 1;
    localparam int SH_W = DATA_WIDTH + 4;

    logic [LC_W-1:0]              lc;
    logic [SH_W-1:0]              lc_ext;
    logic [SH_W-1:0]              esc_thr;
    logic signed [DATA_WIDTH:0]   level_sx;
    logic [DATA_WIDTH:0]          level_abs;
    logic [2:0]                   sl_eff;

    assign lc       = LC_W'(level_code_f(CODE_W'(level), first_flag && (t1s != 2'd3)));
    assign lc_ext   = SH_W'(lc);
    assign esc_thr  = SH_W'(esc_threshold(sl));
    assign level_sx = {level[DATA_WIDTH-1], level};
    assign level_abs = level_sx[DATA_WIDTH] ? unsigned'(-level_sx) : unsigned'(level_sx);
    assign sl_eff   = (sl == 3'd0) ? 3'd1 : sl;

    // Prefix / suffix selection for the current suffix length.
    always_comb begin
        prefix     = '0;
        suffix     = '0;
        suffix_len = '0;
        if (sl == 3'd0) begin
            if (lc_ext < SH_W'(SL0_ESC4_BASE)) begin
                prefix = 4'(lc_ext);
            end else if (lc_ext < SH_W'(SL0_ESC12_BASE)) begin
                prefix     = 4'(SL0_ESC4_BASE);
                suffix     = 12'(lc_ext - SH_W'(SL0_ESC4_BASE));
                suffix_len = 4'd4;
            end else begin
                prefix     = 4'(ESC_PREFIX);
                suffix     = 12'(lc_ext - SH_W'(SL0_ESC12_BASE));
                suffix_len = 4'(ESC_SUFFIX_BITS);
            end
        end else begin
            if (lc_ext < esc_thr) begin
                prefix     = 4'(lc_ext >> sl);
                suffix     = 12'(lc_ext) & ((12'd1 << sl) - 12'd1);
                suffix_len = {1'b0, sl};
            end else begin
                prefix     = 4'(ESC_PREFIX);
                suffix     = 12'(lc_ext - esc_thr);
                suffix_len = 4'(ESC_SUFFIX_BITS);
            end
        end
    end

    // suffixLength to use for the following level.
    always_comb begin
        next_sl = sl_eff;
        if ((CODE_W'(level_abs) > sl_bump_threshold(sl_eff)) && (sl_eff < 3'(MAX_SUFFIX_LEN)))
            next_sl = sl_eff + 3'd1;
    end

endmodule

// File: rtl/cavlc_level_stream_encoder.sv
// CAVLC level encoder: reverse-scans one block, encodes each non-T1 level,
// and streams the codeword bits MSB-first into the bitstream FIFO.
//
//  state     | meaning
//  ----------+---------------------------------------------------------
//  ST_IDLE   | waiting for start_levels
//  ST_READ   | BRAM read issued at addr
//  ST_EVAL   | coefficient valid: skip zero / trailing one, or take it
//  ST_CALC   | register prefix, suffix and next suffixLength
//  ST_PREFIX | emit prefix zeros, then the terminating 1
//  ST_SUFFIX | emit suffix bits MSB-first
//  ST_DONE   | one-cycle finish pulse
module cavlc_level_stream_encoder
    import cavlc_level_pkg::*;
#(
    parameter int DATA_WIDTH   = 9,
    parameter int MAX_COEFF    = 16,
    parameter int NZQ_WIDTH    = 5,
    parameter int ADDR_WIDTH   = $clog2(MAX_COEFF),
    parameter int BITCNT_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_levels,
    output logic                    finish_levels,
    output logic                    busy,
    output logic                    error,
    input  logic [NZQ_WIDTH-1:0]    NZQ,
    input  logic [1:0]              T1s,
    output logic [BITCNT_WIDTH-1:0] bits_written,
    cavlc_level_stream_encoder_if.master bus
);
    state_t state, state_next;

    logic [NZQ_WIDTH-1:0]         nzq_q, coded, coded_inc, coded_target;
    logic [1:0]                   t1s_q, seen;
    logic [ADDR_WIDTH-1:0]        addr;
    logic [2:0]                   sl, next_sl_q, start_sl;
    logic signed [DATA_WIDTH-1:0] level_q;
    logic [3:0]                   prefix_q, suffix_len_q, bit_cnt;
    logic [11:0]                  suffix_q;

    logic [3:0]  calc_prefix, calc_suffix_len;
    logic [11:0] calc_suffix;
    logic [2:0]  calc_next_sl;

    logic full, push, coeff_zero, coeff_skip, addr_zero;
    logic ld_start, count_t1, take_level, dec_addr, set_error;
    logic bit_step, ld_suffix, level_done;

    assign full         = bus.i_fifo_full;
    assign coeff_zero   = (bus.mb_bram_data == '0);
    assign coeff_skip   = coeff_zero || (seen < t1s_q);
    assign addr_zero    = (addr == '0);
    assign coded_inc    = coded + NZQ_WIDTH'(1);
    assign coded_target = nzq_q - NZQ_WIDTH'(t1s_q);
    assign start_sl     = ((NZQ > NZQ_WIDTH'(10)) && (T1s != 2'd3)) ? 3'd1 : 3'd0;

    cavlc_level_code_calc #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_code_calc (
        .level      (level_q),
        .sl         (sl),
        .first_flag (coded == '0),
        .t1s        (t1s_q),
        .prefix     (calc_prefix),
        .suffix     (calc_suffix),
        .suffix_len (calc_suffix_len),
        .next_sl    (calc_next_sl)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    // Next-state logic and datapath strobes.
    always_comb begin
        state_next = state;
        ld_start   = 1'b0;
        count_t1   = 1'b0;
        take_level = 1'b0;
        dec_addr   = 1'b0;
        set_error  = 1'b0;
        bit_step   = 1'b0;
        ld_suffix  = 1'b0;
        level_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_levels) begin
                    ld_start   = 1'b1;
                    state_next = (NZQ == NZQ_WIDTH'(T1s)) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: state_next = ST_EVAL;
            ST_EVAL: begin
                if (coeff_skip) begin
                    count_t1 = !coeff_zero;
                    if (addr_zero) begin
                        set_error  = 1'b1;
                        state_next = ST_DONE;
                    end else begin
                        dec_addr   = 1'b1;
                        state_next = ST_READ;
                    end
                end else begin
                    take_level = 1'b1;
                    state_next = ST_CALC;
                end
            end
            ST_CALC: state_next = ST_PREFIX;
            ST_PREFIX: begin
                if (!full) begin
                    if (bit_cnt != 4'd0) begin
                        bit_step = 1'b1;
                    end else if (suffix_len_q != 4'd0) begin
                        ld_suffix  = 1'b1;
                        state_next = ST_SUFFIX;
                    end else begin
                        level_done = 1'b1;
                    end
                end
            end
            ST_SUFFIX: begin
                if (!full) begin
                    if (bit_cnt != 4'd0) bit_step = 1'b1;
                    else                 level_done = 1'b1;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase

        if (level_done) begin
            if (coded_inc == coded_target) begin
                state_next = ST_DONE;
            end else if (addr_zero) begin
                set_error  = 1'b1;
                state_next = ST_DONE;
            end else begin
                dec_addr   = 1'b1;
                state_next = ST_READ;
            end
        end
    end

    // Outputs decoded from state; all fall to 0 the moment reset asserts.
    always_comb begin
        busy                = (state != ST_IDLE);
        finish_levels       = (state == ST_DONE);
        bus.mb_bram_en      = (state == ST_READ);
        bus.mb_bram_address = addr;
        push                = ((state == ST_PREFIX) || (state == ST_SUFFIX)) && !full;
        bus.o_fifo_push     = push;
        bus.o_fifo_data     = 1'b0;
        if (state == ST_PREFIX)      bus.o_fifo_data = (bit_cnt == 4'd0);
        else if (state == ST_SUFFIX) bus.o_fifo_data = suffix_q[bit_cnt];
    end

    // Block context, scan position, per-level codeword and bit counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nzq_q        <= '0;
            t1s_q        <= '0;
            addr         <= '0;
            seen         <= '0;
            coded        <= '0;
            sl           <= '0;
            level_q      <= '0;
            prefix_q     <= '0;
            suffix_q     <= '0;
            suffix_len_q <= '0;
            next_sl_q    <= '0;
            bit_cnt      <= '0;
            error        <= 1'b0;
            bits_written <= '0;
        end else begin
            if (ld_start) begin
                nzq_q        <= NZQ;
                t1s_q        <= T1s;
                addr         <= ADDR_WIDTH'(MAX_COEFF - 1);
                seen         <= '0;
                coded        <= '0;
                sl           <= start_sl;
                error        <= 1'b0;
                bits_written <= '0;
            end
            if (set_error)  error   <= 1'b1;
            if (count_t1)   seen    <= seen + 2'd1;
            if (dec_addr)   addr    <= addr - ADDR_WIDTH'(1);
            if (take_level) level_q <= bus.mb_bram_data;
            if (state == ST_CALC) begin
                prefix_q     <= calc_prefix;
                suffix_q     <= calc_suffix;
                suffix_len_q <= calc_suffix_len;
                next_sl_q    <= calc_next_sl;
                bit_cnt      <= calc_prefix;
            end
            if (bit_step)  bit_cnt <= bit_cnt - 4'd1;
            if (ld_suffix) bit_cnt <= suffix_len_q - 4'd1;
            if (push && (bits_written != '1))
                bits_written <= bits_written + BITCNT_WIDTH'(1);
            if (level_done) begin
                coded <= coded_inc;
                sl    <= next_sl_q;
            end
        end
    end

endmodule

// File: tb/tb_cavlc_level_stream_encoder.sv
// Directed bench for the CAVLC level encoder: BRAM model, FIFO bit capture,
// one task per scenario with hand-computed streams and cycle counts.
module tb_cavlc_level_stream_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_levels;
    logic       finish_levels;
    logic       busy;
    logic       error;
    logic [4:0] NZQ;
    logic [1:0] T1s;
    logic [9:0] bits_written;

    int checks = 0;
    int errors = 0;

    cavlc_level_stream_encoder_if #(.DATA_WIDTH(9), .ADDR_WIDTH(4)) bus ();

    cavlc_level_stream_encoder #(
        .DATA_WIDTH(9), .MAX_COEFF(16), .NZQ_WIDTH(5), .ADDR_WIDTH(4), .BITCNT_WIDTH(10)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_levels  (start_levels),
        .finish_levels (finish_levels),
        .busy          (busy),
        .error         (error),
        .NZQ           (NZQ),
        .T1s           (T1s),
        .bits_written  (bits_written),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    logic signed [8:0] mem [16];
    logic cap_bits [4096];
    int   cap_len   = 0;
    int   en_cnt    = 0;
    int   full_push = 0;

    // BRAM model: one-cycle read latency.
    always @(posedge clk) begin
        if (bus.mb_bram_en) bus.mb_bram_data <= mem[bus.mb_bram_address];
    end

    // FIFO side: capture pushed bits, count reads and pushes made while full.
    always @(posedge clk) begin
        if (bus.o_fifo_push) begin
            cap_bits[cap_len] = bus.o_fifo_data;
            cap_len = cap_len + 1;
            if (bus.i_fifo_full) full_push = full_push + 1;
        end
        if (bus.mb_bram_en) en_cnt = en_cnt + 1;
    end

    function automatic logic [63:0] stream_since(input int base);
        logic [63:0] v = '0;
        for (int i = base; i < cap_len; i++) v = {v[62:0], cap_bits[i]};
        return v;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = '0;
    endtask

    // Called #1 after an edge; start is sampled at the next edge (edge 0).
    task automatic start_block(input int nzq, input int t1s);
        NZQ = 5'(nzq);
        T1s = 2'(t1s);
        start_levels = 1'b1;
        @(posedge clk); #1;
        start_levels = 1'b0;
    endtask

    // Returns the cycle number in which finish_levels is seen, or -1 on timeout.
    task automatic wait_finish(output int cyc);
        cyc = 1;
        while (!finish_levels && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!finish_levels) cyc = -1;
    endtask

    task automatic test_reset();
        checks++;
        if ({finish_levels, busy, error, bus.mb_bram_en, bus.o_fifo_push, bus.o_fifo_data} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {finish_levels, busy, error, bus.mb_bram_en, bus.o_fifo_push, bus.o_fifo_data});
        end
        checks++;
        if (bits_written !== 10'd0 || bus.mb_bram_address !== 4'd0) begin
            errors++;
            $display("FAIL reset_counts: bits_written %0d addr %0d expected 0 0",
                     bits_written, bus.mb_bram_address);
        end
    endtask

    task automatic test_small_level();
        int cyc, base;
        clear_mem();
        mem[15] = 9'sd3;
        base = cap_len;
        start_block(1, 0);
        checks++;
        if (busy !== 1'b1 || bus.mb_bram_en !== 1'b1) begin
            errors++;
            $display("FAIL small_first_read: busy %b en %b expected 1 1", busy, bus.mb_bram_en);
        end
        wait_finish(cyc);
        checks++;
        if (cyc != 7) begin errors++; $display("FAIL small_finish_cycle: got %0d expected 7", cyc); end
        checks++;
        if (cap_len - base != 3) begin errors++; $display("FAIL small_len: got %0d expected 3", cap_len - base); end
        checks++;
        if (stream_since(base) !== 64'd1) begin
            errors++; $display("FAIL small_bits: got %0h expected 1", stream_since(base));
        end
        checks++;
        if (bits_written !== 10'd3) begin errors++; $display("FAIL small_bits_written: got %0d expected 3", bits_written); end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || finish_levels !== 1'b0) begin
            errors++; $display("FAIL small_idle: busy %b finish %b expected 0 0", busy, finish_levels);
        end
    endtask

    task automatic setup_esc4();
        clear_mem();
        mem[15] = 9'sd1;
        mem[14] = -9'sd1;
        mem[12] = 9'sd1;
        mem[11] = 9'sd8;
    endtask

    task automatic test_esc4();
        int cyc, base;
        setup_esc4();
        base = cap_len;
        start_block(4, 3);
        wait_finish(cyc);
        checks++;
        if (cyc != 31) begin errors++; $display("FAIL esc4_finish_cycle: got %0d expected 31", cyc); end
        checks++;
        if (cap_len - base != 19) begin errors++; $display("FAIL esc4_len: got %0d expected 19", cap_len - base); end
        checks++;
        if (stream_since(base) !== 64'd16) begin
            errors++; $display("FAIL esc4_bits: got %0h expected 10", stream_since(base));
        end
        checks++;
        if (bits_written !== 10'd19) begin errors++; $display("FAIL esc4_bits_written: got %0d expected 19", bits_written); end
        @(posedge clk); #1;
    endtask

    task automatic setup_esc12();
        clear_mem();
        mem[15] = -9'sd20;
        mem[14] = 9'sd3;
    endtask

    // -20 -> 15 zeros,1,000000000111; then +3 at sl=2 -> 01 00; then scan underflow.
    task automatic test_esc12();
        int cyc, base;
        setup_esc12();
        base = cap_len;
        start_block(11, 0);
        wait_finish(cyc);
        checks++;
        if (cyc != 67) begin errors++; $display("FAIL esc12_finish_cycle: got %0d expected 67", cyc); end
        checks++;
        if (cap_len - base != 32) begin errors++; $display("FAIL esc12_len: got %0d expected 32", cap_len - base); end
        checks++;
        if (stream_since(base) !== 64'h10074) begin
            errors++; $display("FAIL esc12_bits: got %0h expected 10074", stream_since(base));
        end
        checks++;
        if (error !== 1'b1 || bits_written !== 10'd32) begin
            errors++; $display("FAIL esc12_status: error %b bits_written %0d expected 1 32", error, bits_written);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int cyc, base, fp0;
        setup_esc12();
        base = cap_len;
        fp0  = full_push;
        start_block(11, 0);
        cyc = 1;
        while (!finish_levels && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 10) bus.i_fifo_full = 1'b1;
            if (cyc == 15) bus.i_fifo_full = 1'b0;
            if (cyc == 12) begin
                checks++;
                if (bus.o_fifo_push !== 1'b0) begin
                    errors++; $display("FAIL bp_push_while_full: got %b expected 0", bus.o_fifo_push);
                end
            end
        end
        bus.i_fifo_full = 1'b0;
        checks++;
        if (cyc != 72 || !finish_levels) begin errors++; $display("FAIL bp_finish_cycle: got %0d expected 72", cyc); end
        checks++;
        if (cap_len - base != 32 || stream_since(base) !== 64'h10074) begin
            errors++; $display("FAIL bp_bits: got %0h len %0d expected 10074 len 32", stream_since(base), cap_len - base);
        end
        checks++;
        if (full_push - fp0 != 0) begin errors++; $display("FAIL bp_full_pushes: got %0d expected 0", full_push - fp0); end
        @(posedge clk); #1;
    endtask

    // Only two nonzeros for NZQ=3: +2 -> "1", -2 -> "011", then underflow at addr 0.
    task automatic test_error();
        int cyc, base;
        clear_mem();
        mem[10] = 9'sd2;
        mem[5]  = -9'sd2;
        base = cap_len;
        start_block(3, 0);
        wait_finish(cyc);
        checks++;
        if (cyc != 39) begin errors++; $display("FAIL err_finish_cycle: got %0d expected 39", cyc); end
        checks++;
        if (error !== 1'b1) begin errors++; $display("FAIL err_flag: got %b expected 1", error); end
        checks++;
        if (cap_len - base != 4 || stream_since(base) !== 64'd11) begin
            errors++; $display("FAIL err_bits: got %0h len %0d expected b len 4", stream_since(base), cap_len - base);
        end
        @(posedge clk); #1;
        checks++;
        if (error !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", error); end
    endtask

    task automatic test_empty();
        int cyc, base, en0;
        base = cap_len;
        en0  = en_cnt;
        start_block(2, 2);
        wait_finish(cyc);
        checks++;
        if (cyc != 1) begin errors++; $display("FAIL empty_finish_cycle: got %0d expected 1", cyc); end
        checks++;
        if (error !== 1'b0) begin errors++; $display("FAIL empty_error_cleared: got %b expected 0", error); end
        @(posedge clk); #1;
        checks++;
        if (en_cnt - en0 != 0 || cap_len - base != 0) begin
            errors++; $display("FAIL empty_activity: reads %0d pushes %0d expected 0 0", en_cnt - en0, cap_len - base);
        end
        checks++;
        if (finish_levels !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL empty_pulse: finish %b busy %b expected 0 0", finish_levels, busy);
        end
    endtask

    task automatic test_reset_mid_suffix();
        int cyc;
        setup_esc4();
        start_block(4, 3);
        cyc = 1;
        while (cyc < 28) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (bus.o_fifo_push !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL rst_mid_active: push %b busy %b expected 1 1", bus.o_fifo_push, busy);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({finish_levels, busy, error, bus.mb_bram_en, bus.o_fifo_push, bus.o_fifo_data} !== 6'b0
            || bits_written !== 10'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs: flags %b bits_written %0d expected 000000 0",
                     {finish_levels, busy, error, bus.mb_bram_en, bus.o_fifo_push, bus.o_fifo_data}, bits_written);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        test_small_level();
    endtask

    initial begin
        rst          = 1'b1;
        start_levels = 1'b0;
        NZQ          = '0;
        T1s          = '0;
        bus.i_fifo_full = 1'b0;
        clear_mem();
        #2 rst = 1'b0;
        #10;
        test_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        test_small_level();
        test_esc4();
        test_esc12();
        test_backpressure();
        test_error();
        test_empty();
        test_reset_mid_suffix();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
